// File: rtl/udiv_seq_if.sv
// ---------------------------------------------------------------------------
// udiv_seq_if
// Request/result handshake bundle for the iterative unsigned divider.
//
//   in_valid     master -> slave   request valid
//   in_ready     slave  -> master  divider can accept a request
//   dividend     master -> slave   unsigned dividend (DW_N bits)
//   divisor      master -> slave   unsigned divisor  (DW_D bits)
//   out_valid    slave  -> master  result valid
//   out_ready    master -> slave   consumer accepts the result
//   quotient     slave  -> master  unsigned quotient (DW_N bits)
//   remainder    slave  -> master  unsigned remainder (DW_D bits)
//   div_by_zero  slave  -> master  result came from a divisor==0 request
// ---------------------------------------------------------------------------
interface udiv_seq_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/udiv_seq.sv
// ---------------------------------------------------------------------------
// udiv_seq
// Iterative unsigned restoring divider, one quotient bit per clock.
// A DW_N-bit dividend is divided by a DW_D-bit divisor; the result is held
// on the result port until the consumer takes it.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    udiv_seq_if.slave: request (in_valid/in_ready/dividend/divisor)
//          and result (out_valid/out_ready/quotient/remainder/div_by_zero)
//
// Timing: a normal request enters DONE DW_N edges after its accept edge; a
// divisor of zero goes straight to DONE on the accept edge. The result
// registers change only on entry to DONE, so they keep their last value
// after the result has been consumed.
// ---------------------------------------------------------------------------
module udiv_seq #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    udiv_seq_if.slave bus
);

    localparam int CW = $clog2(DW_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   count;
    logic [DW_D-1:0] part_rem;   // partial remainder, always < divisor
    logic [DW_N-1:0] shift_q;    // dividend bits shifting out, quotient bits shifting in
    logic [DW_D-1:0] div_reg;

    logic [DW_N-1:0] quot_reg;
    logic [DW_D-1:0] rem_reg;
    logic            dbz_reg;

    logic            in_ready_s;
    logic            out_valid_s;
    logic            accept;
    logic            last_step;

    // Restoring step datapath
    logic            shift_hi;
    logic [DW_D-1:0] shift_lo;
    logic            q_bit;
    logic [DW_D-1:0] rem_step;
    logic [DW_N-1:0] q_step;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == RUN) && (count == CW'(DW_N - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every
    // always_ff block sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statement, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        state_next  = state;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    state_next = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_s = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One restoring step. The shifted remainder is DW_D+1 bits wide; it is
    // kept as a separate top bit plus DW_D low bits. If the top bit is set
    // the value certainly exceeds the divisor, and the true difference is
    // below the divisor, so the low DW_D bits of the subtraction are exact.
    // ------------------------------------------------------------------
    always_comb begin
        shift_hi = part_rem[DW_D-1];
        shift_lo = {part_rem[DW_D-2:0], shift_q[DW_N-1]};
        q_bit    = shift_hi || (shift_lo >= div_reg);
        rem_step = q_bit ? (shift_lo - div_reg) : shift_lo;
        q_step   = {shift_q[DW_N-2:0], q_bit};
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            part_rem <= '0;
            shift_q  <= '0;
            div_reg  <= '0;
            quot_reg <= '0;
            rem_reg  <= '0;
            dbz_reg  <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            part_rem <= '0;
            shift_q  <= bus.dividend;
            div_reg  <= bus.divisor;
            if (bus.divisor == '0) begin
                quot_reg <= '1;
                rem_reg  <= bus.dividend[DW_D-1:0];
                dbz_reg  <= 1'b1;
            end
        end else if (state == RUN) begin
            count    <= count + 1'b1;
            part_rem <= rem_step;
            shift_q  <= q_step;
            if (last_step) begin
                quot_reg <= q_step;
                rem_reg  <= rem_step;
                dbz_reg  <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_udiv_seq.sv
// ---------------------------------------------------------------------------
// tb_udiv_seq
// Directed bench for udiv_seq: reset state, corner divisions, divide by zero,
// result backpressure, back-to-back throughput, reset during an operation,
// and a stalled sweep against a division model.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udiv_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    udiv_seq_if #(.DW_N(16), .DW_D(8)) bus ();

    udiv_seq #(.DW_N(16), .DW_D(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request, wait for it to be accepted, then count edges after
    // the accept edge until out_valid is seen (-1 if it never appears).
    // With hold=0 the operands are scrambled right after the accept edge.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input int pre_stall, input bit hold, output int lat);
        int n;
        repeat (pre_stall) begin @(posedge clk); #1; end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.dividend = ~a;
            bus.divisor  = ~b;
        end
        lat = 0;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic finish_op(input int post_stall);
        repeat (post_stall) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #12;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'h0 ||
            bus.remainder !== 8'h0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b want 1 0 0000 00 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        int lat;
        run_op(16'hFFFF, 8'hFF, 0, 1'b0, lat);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL max_latency got %0d want 16", lat); end
        checks++;
        if (bus.quotient !== 16'h0101 || bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL max_result got q=%h r=%h dz=%b want 0101 00 0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        finish_op(0);
    endtask

    task automatic test_basic();
        int lat;
        run_op(16'd1000, 8'd7, 1, 1'b1, lat);
        checks++;
        if (lat !== 16 || bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
            errors++;
            $display("FAIL div_1000_7 got lat=%0d q=%0d r=%0d want 16 142 6",
                     lat, bus.quotient, bus.remainder);
        end
        finish_op(2);
        run_op(16'd5, 8'd200, 0, 1'b0, lat);
        checks++;
        if (lat !== 16 || bus.quotient !== 16'd0 || bus.remainder !== 8'd5) begin
            errors++;
            $display("FAIL div_5_200 got lat=%0d q=%0d r=%0d want 16 0 5",
                     lat, bus.quotient, bus.remainder);
        end
        finish_op(0);
    endtask

    // Divide by zero enters DONE on the accept edge itself: out_valid is up
    // one edge after the request is presented, zero edges after acceptance.
    task automatic test_div_zero();
        int lat;
        run_op(16'h1234, 8'h00, 0, 1'b0, lat);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL dbz_latency got %0d want 0", lat); end
        checks++;
        if (bus.quotient !== 16'hFFFF || bus.remainder !== 8'h34 || bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%h dz=%b want ffff 34 1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        finish_op(1);
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(16'd50000, 8'd9, 0, 1'b0, lat);
        bus.in_valid = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 16'd5555 ||
                bus.remainder !== 8'd5 || bus.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b q=%0d r=%0d dz=%b want 1 0 5555 5 0",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 16'd5555) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b q=%0d want 0 1 5555",
                     bus.out_valid, bus.in_ready, bus.quotient);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_accept got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    // Requests and results kept flowing: result-to-result spacing is one
    // handshake edge, one accept edge and DW_N run edges.
    task automatic test_back_to_back();
        int  n;
        int  e;
        bit  seen_low;
        bus.dividend  = 16'd1000;
        bus.divisor   = 8'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        e = 0;
        seen_low = 1'b0;
        while (e < 100) begin
            @(posedge clk); #1;
            e++;
            if (!bus.out_valid) seen_low = 1'b1;
            else if (seen_low) break;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (e !== 18) begin errors++; $display("FAIL b2b_spacing got %0d want 18", e); end
        checks++;
        if (bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
            errors++;
            $display("FAIL b2b_result got q=%0d r=%0d want 142 6", bus.quotient, bus.remainder);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int n;
        bus.dividend = 16'd4000;
        bus.divisor  = 8'd13;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 16'h0 ||
            bus.remainder !== 8'h0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run got rdy=%b vld=%b q=%h r=%h dz=%b want 1 0 0000 00 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        run_op(16'd4000, 8'd13, 0, 1'b0, lat);
        checks++;
        if (lat !== 16 || bus.quotient !== 16'd307 || bus.remainder !== 8'd9) begin
            errors++;
            $display("FAIL after_reset got lat=%0d q=%0d r=%0d want 16 307 9",
                     lat, bus.quotient, bus.remainder);
        end
        finish_op(0);
    endtask

    task automatic check_one(input logic [15:0] a, input logic [7:0] b, input string tag);
        int          lat;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ed;
        int          el;
        if (b == 8'd0) begin
            eq = 16'hFFFF; er = a[7:0]; ed = 1'b1; el = 0;
        end else begin
            eq = a / b;
            er = 8'(a % b);
            ed = 1'b0;
            el = 16;
        end
        run_op(a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat);
        checks++;
        if (lat !== el || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ed) begin
            errors++;
            $display("FAIL %s %0d/%0d got lat=%0d q=%0d r=%0d dz=%b want %0d %0d %0d %b",
                     tag, a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, el, eq, er, ed);
        end
        finish_op($urandom_range(0, 3));
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 250; i++) begin
            check_one(16'($urandom), 8'($urandom_range(0, 255)), "random");
        end
        for (int x = 1; x <= 255; x += 23) begin
            for (int y = 1; y <= 255; y += 29) begin
                check_one(16'(x * y), 8'(y), "exact");
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
